// File: rtl/oscilo_pkg.sv
// oscilo_pkg: shared reader state encoding and stream header constants
package oscilo_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_CAP,
    ST_HEADER,
    ST_STREAM,
    ST_RELEASE
  } state_e;
  localparam logic [7:0] HDR_SYNC = 8'hA5;
  localparam int HDR_LEN = 4;
endpackage

// File: rtl/skid_buf.sv
// skid_buf: 2-entry output FIFO whose head register drives the stream directly
module skid_buf #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d, slot;
  logic pop;
  always_comb begin
    pop = (cnt_q != 2'd0) && out_ready;
    slot = cnt_q - {1'b0, pop};
    cnt_d = cnt_q + {1'b0, in_valid} - {1'b0, pop};
    e0_d = (in_valid && slot == 2'd0) ? in_data : pop ? e1_q : e0_q;
    e1_d = (in_valid && slot == 2'd1) ? in_data : e1_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q <= '0;
      e1_q <= '0;
      cnt_q <= '0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      cnt_q <= cnt_d;
    end
  end
  assign out_valid = cnt_q != 2'd0;
  assign out_data = e0_q;
  assign count = cnt_q;
endmodule

// File: rtl/capture_reader.sv
// capture_reader: streams a header plus a full capture buffer, oldest sample first
module capture_reader
  import oscilo_pkg::*;
#(
  parameter int SAMPLE_DEPTH = 1024,
  parameter logic [7:0] module_id = 8'h11
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            cap_done,
  input  logic [$clog2(SAMPLE_DEPTH)-1:0] cap_wr_ptr,
  input  logic [$clog2(SAMPLE_DEPTH)-1:0] cap_trig_addr,
  output logic                            rd_release,
  output logic [$clog2(SAMPLE_DEPTH)-1:0] m_addr,
  output logic                            m_re,
  input  logic [7:0]                      m_rdata,
  output logic [7:0]                      tx_data,
  output logic                            tx_valid,
  input  logic                            tx_ready,
  output logic                            tx_last,
  output logic                            busy
);
  localparam int AW = $clog2(SAMPLE_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(SAMPLE_DEPTH);
  state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, trig_q, trig_d;
  logic [AW:0] rd_cnt_q, rd_cnt_d;
  logic [1:0] hdr_q, hdr_d, fifo_cnt, occ;
  logic pend_q, pend_d, pend_last_q, pend_last_d;
  logic pop, space, hdr_push, push;
  logic [15:0] trig16;
  logic [7:0] hdr_byte;
  logic [8:0] push_data, head;
  always_comb begin
    pop = tx_valid && tx_ready;
    // occupancy includes the read whose data lands next cycle
    occ = fifo_cnt + {1'b0, pend_q};
    space = (occ < 2'd2) || (pop && occ == 2'd2);
    trig16 = 16'(trig_q);
    hdr_byte = hdr_q == 2'd0 ? HDR_SYNC : hdr_q == 2'd1 ? module_id :
               hdr_q == 2'd2 ? trig16[15:8] : trig16[7:0];
    m_re = state_q == ST_STREAM && rd_cnt_q < DEPTH_C && space;
    hdr_push = state_q == ST_HEADER && space;
    push = hdr_push || pend_q;
    push_data = pend_q ? {pend_last_q, m_rdata} : {1'b0, hdr_byte};
    pend_d = m_re;
    pend_last_d = m_re && rd_cnt_q == DEPTH_C - 1'b1;
    addr_d = m_re ? addr_q + 1'b1 : addr_q;
    rd_cnt_d = m_re ? rd_cnt_q + 1'b1 : rd_cnt_q;
    trig_d = trig_q;
    hdr_d = hdr_q;
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = start ? ST_WAIT_CAP : ST_IDLE;
      ST_WAIT_CAP: if (cap_done) begin
        addr_d = cap_wr_ptr;
        trig_d = cap_trig_addr - cap_wr_ptr;
        hdr_d = '0;
        rd_cnt_d = '0;
        state_d = ST_HEADER;
      end
      ST_HEADER: if (hdr_push) begin
        hdr_d = hdr_q + 1'b1;
        state_d = hdr_q == 2'(HDR_LEN - 1) ? ST_STREAM : ST_HEADER;
      end
      ST_STREAM: state_d = (pop && tx_last) ? ST_RELEASE : ST_STREAM;
      ST_RELEASE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q <= '0;
      trig_q <= '0;
      rd_cnt_q <= '0;
      hdr_q <= '0;
      pend_q <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      trig_q <= trig_d;
      rd_cnt_q <= rd_cnt_d;
      hdr_q <= hdr_d;
      pend_q <= pend_d;
      pend_last_q <= pend_last_d;
    end
  end
  skid_buf #(.W(9)) u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(push),
    .in_data(push_data),
    .out_ready(tx_ready),
    .out_valid(tx_valid),
    .out_data(head),
    .count(fifo_cnt)
  );
  assign tx_data = head[7:0];
  assign tx_last = tx_valid && head[8];
  assign m_addr = addr_q;
  assign rd_release = state_q == ST_RELEASE;
  assign busy = state_q != ST_IDLE;
endmodule
